// File: rtl/seq_bit_serializer_if.sv
// Word handshake and serial output bundle for seq_bit_serializer.
// The master side supplies words; the slave side is the serializer.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, word_done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, word_done, busy
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the Moore 101 detector (sout feeds its bit input).
// Words arrive over a valid/ready handshake and leave one bit per clock; a
// one-word holding register plus a last-bit bypass keep consecutive words gapless.
// Optional macro SER_PARITY_EN appends an even-parity bit (XOR of the word).
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_bit_serializer_if.slave     bus_io
);

`ifdef SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);
`ifdef SER_PARITY_EN
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             word_done_q, word_done_d;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             xfer;
  logic             last_bit;
  logic             load;
  logic [WIDTH-1:0] load_word;

  // Bit that leaves the shifter next, depending on shift direction.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // Shifter contents after the head bit has been emitted.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  assign xfer     = bus_io.din_valid && !hold_valid_q;
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

  assign bus_io.din_ready  = !hold_valid_q;
  assign bus_io.sout       = sout_q;
  assign bus_io.sout_valid = sout_valid_q;
  assign bus_io.word_done  = word_done_q;
  assign bus_io.busy       = (state_q == SHIFT) || hold_valid_q;

  // State register: every control and data register, reset to idle/empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      cnt_q        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      word_done_q  <= 1'b0;
`ifdef SER_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      cnt_q        <= cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      word_done_q  <= word_done_d;
`ifdef SER_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  // Next state: leave SHIFT only when the last bit goes out with nothing to reload.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = SHIFT;
      SHIFT:   if (last_bit && !hold_valid_q && !xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs: load, shift, hold capture and done pulse.
  always_comb begin
    sh_d         = sh_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    cnt_d        = cnt_q;
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    load         = 1'b0;
    load_word    = '0;
`ifdef SER_PARITY_EN
    par_d        = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (xfer) begin
          load      = 1'b1;
          load_word = bus_io.din;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          // Held word has priority; otherwise a word offered now bypasses the hold.
          if (hold_valid_q) begin
            load         = 1'b1;
            load_word    = hold_q;
            hold_valid_d = 1'b0;
          end else if (xfer) begin
            load      = 1'b1;
            load_word = bus_io.din;
          end
        end else begin
          cnt_d        = cnt_q + CW'(1);
          sout_valid_d = 1'b1;
          sout_d       = head_bit(sh_q);
          sh_d         = advance(sh_q);
`ifdef SER_PARITY_EN
          if (cnt_q == LAST_DATA) sout_d = par_q;
`endif
          if (xfer) begin
            hold_d       = bus_io.din;
            hold_valid_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (load) begin
      sh_d         = advance(load_word);
      cnt_d        = '0;
      sout_d       = head_bit(load_word);
      sout_valid_d = 1'b1;
`ifdef SER_PARITY_EN
      par_d        = ^load_word;
`endif
    end

    word_done_d = sout_valid_d && (cnt_d == LAST);
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed table-driven bench for seq_bit_serializer (WIDTH=8, MSB first).
module tb_seq_bit_serializer;

`ifdef SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_bit_serializer_if #(.WIDTH(8)) bus ();

  seq_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] din;
    logic       sout;
    logic       sv;
    logic       wd;
    logic       busy;
    logic       rdy;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] d,
                     input logic s, input logic sv, input logic wd,
                     input logic b, input logic rd, input string n);
    vec_t e;
    e.rst = r; e.vld = v; e.din = d; e.sout = s; e.sv = sv; e.wd = wd;
    e.busy = b; e.rdy = rd; e.name = n;
    vecs.push_back(e);
  endtask

  // Rows for serial positions from..to (1-based) of a hand-written bit pattern
  // pat (first bit in pat[n-1]); done expected on position n.
  task automatic tail(input logic [8:0] pat, input int from, input int to, input int n,
                      input logic v, input logic [7:0] d, input logic rd, input string nm);
    for (int p = from; p <= to; p++)
      add(1'b0, v, d, pat[n-p], 1'b1, (p == n), 1'b1, rd, nm);
  endtask

  logic [7:0] w3 [3];
  int   sent, nvalid, ndone, first_c, last_c;
  logic go;

  initial begin
    bus.din       = 8'h00;
    bus.din_valid = 1'b0;

    // reset with din_valid high: nothing may be accepted
    add(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst0");
    add(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst1");
`ifndef SER_PARITY_EN
    // single word A5 = 10100101, din changed after accept
    add(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "single_acc");
    tail(9'b0_1010_0101, 2, 8, 8, 1'b0, 8'h5A, 1'b1, "single");
    add(1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "single_idle");
    // back-to-back B4 = 10110100, 0F = 00001111 through the hold register
    add(1'b0, 1'b1, 8'hB4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "b2b_acc");
    tail(9'b0_1011_0100, 2, 8, 8, 1'b1, 8'h0F, 1'b0, "b2b_w1");
    add(1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "b2b_reload");
    tail(9'b0_0000_1111, 2, 8, 8, 1'b0, 8'h00, 1'b1, "b2b_w2");
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "b2b_idle");
    // bypass: FF offered only on the last-bit cycle of A5
    add(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "byp_acc");
    tail(9'b0_1010_0101, 2, 8, 8, 1'b0, 8'h00, 1'b1, "byp_w1");
    add(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "byp_load");
    tail(9'b0_1111_1111, 2, 8, 8, 1'b0, 8'h00, 1'b1, "byp_w2");
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "byp_idle");
    // reset during bit 3 of A5 with 3C held, then 01 = 00000001
    add(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "mid_acc");
    add(1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "mid_hold");
    add(1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "mid_bit3");
    add(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "mid_rst");
    add(1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "mid_after");
    add(1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "fresh_acc");
    tail(9'b0_0000_0001, 2, 8, 8, 1'b0, 8'h00, 1'b1, "fresh");
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "fresh_idle");
`else
    // 07 -> 00000111 + parity 1 ; 03 -> 00000011 + parity 0
    add(1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "par07_acc");
    tail(9'b0_0000_1111, 2, 9, 9, 1'b0, 8'h00, 1'b1, "par07");
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "par07_idle");
    add(1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "par03_acc");
    tail(9'b0_0000_0110, 2, 9, 9, 1'b0, 8'h00, 1'b1, "par03");
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "par03_idle");
`endif

    @(negedge clk);
    foreach (vecs[i]) begin
      rst           = vecs[i].rst;
      bus.din_valid = vecs[i].vld;
      bus.din       = vecs[i].din;
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_sout"},  bus.sout,       vecs[i].sout);
      chk({vecs[i].name, "_sv"},    bus.sout_valid, vecs[i].sv);
      chk({vecs[i].name, "_done"},  bus.word_done,  vecs[i].wd);
      chk({vecs[i].name, "_busy"},  bus.busy,       vecs[i].busy);
      chk({vecs[i].name, "_ready"}, bus.din_ready,  vecs[i].rdy);
      @(negedge clk);
    end

    // Three words offered continuously: the stream must be gapless.
    w3[0] = 8'h12; w3[1] = 8'h34; w3[2] = 8'h56;
    sent = 0; nvalid = 0; ndone = 0; first_c = -1; last_c = -1;
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (sent < 3) begin
        bus.din_valid = 1'b1;
        bus.din       = w3[sent];
      end else begin
        bus.din_valid = 1'b0;
      end
      go = bus.din_valid && bus.din_ready;
      @(posedge clk);
      #1;
      if (go) sent++;
      if (bus.sout_valid) begin
        nvalid++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      if (bus.word_done) ndone++;
      @(negedge clk);
    end
    chk("stream_sent",   sent,                3);
    chk("stream_valid",  nvalid,              3 * NB);
    chk("stream_done",   ndone,               3);
    chk("stream_nogap",  last_c - first_c + 1, 3 * NB);
    chk("stream_busy",   bus.busy,            1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, expected finish");
    $fatal(1, "timeout");
  end

endmodule
